// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instr_mem_pkg;

    typedef enum logic [0:0] {
        StInit,
        StReady
    } state_e;

    localparam int unsigned DefaultDataW = 32;
    localparam logic [DefaultDataW-1:0] DefaultNopWord = '0;

endpackage

// File: rtl/instr_mem_array.sv
// Word storage: one synchronous write port, one combinational read port.
module instr_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Callers keep waddr/raddr below DEPTH; no reset, contents are cleared by the INIT sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory with a load port, reset-time NOP fill sweep and a registered fetch stage
// supporting stall, flush and write-first bypass. addr_err is registered alongside instr.
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int unsigned       DATA_W   = DefaultDataW,
    parameter int unsigned       ADDR_W   = 5,
    parameter int unsigned       DEPTH    = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DefaultNopWord)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              addr_err,
    output logic              busy
);

    localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              ready;
    logic              ld_accept;
    logic              ld_oor;
    logic              rd_oor;
    logic              fetch_go;
    logic              bypass;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign ready     = (state_q == StReady);
    assign ld_oor    = {1'b0, ld_addr} >= DepthExt;
    assign rd_oor    = {1'b0, rd_addr} >= DepthExt;
    assign ld_accept = ld_valid & ready;
    assign fetch_go  = ready & rd_en & ~stall & ~flush;
    assign bypass    = ld_accept & ~ld_oor & (ld_addr == rd_addr);

    // Write port: INIT sweep owns the array; otherwise in-range accepted loads.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
        if (!reset) begin
            if (state_q == StInit) begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt_q;
                mem_wdata = NOP_WORD;
            end else if (ld_accept && !ld_oor) begin
                mem_we = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            StInit: begin
                if (init_cnt_q == LastAddr) begin
                    state_d = StReady;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
                end
            end
            StReady: state_d = StReady;
            default: state_d = StInit;
        endcase
    end

    // Fetch stage: flush beats stall beats rd_en.
    always_comb begin
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        addr_err_d    = (fetch_go & rd_oor) | (ld_accept & ld_oor);
        if (flush) begin
            instr_d = NOP_WORD;
        end else if (stall) begin
            instr_valid_d = instr_valid_q;
        end else if (fetch_go) begin
            instr_valid_d = 1'b1;
            if (rd_oor) begin
                instr_d = NOP_WORD;
            end else if (bypass) begin
                instr_d = ld_data;
            end else begin
                instr_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StInit;
            init_cnt_q    <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    instr_mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(rd_addr),
        .rdata(mem_rdata)
    );

    assign ld_ready    = ready;
    assign busy        = (state_q == StInit);
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;

endmodule

// File: doc/instr_mem_loadable.md
INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 5: address width in bits.
REQ-003 Parameter DEPTH, default 32: number of words, with 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter NOP_WORD, default all-zero DATA_W: fill and flush value.
REQ-005 clk  in  1: single clock; all state updates on rising edge.
REQ-006 reset  in  1: synchronous, active-high reset.
REQ-007 ld_valid  in  1: load-port write request.
REQ-008 ld_addr  in  ADDR_W: load-port word address.
REQ-009 ld_data  in  DATA_W: load-port write data.
REQ-010 ld_ready  out  1: load port accepting; high only in READY.
REQ-011 rd_en  in  1: fetch request.
REQ-012 rd_addr  in  ADDR_W: fetch word address (PC index).
REQ-013 stall  in  1: hold fetch output.
REQ-014 flush  in  1: kill fetch output.
REQ-015 instr  out  DATA_W: fetched instruction, registered.
REQ-016 instr_valid  out  1: instr holds a valid fetch.
REQ-017 addr_err  out  1: one-cycle pulse when an accepted access targets an address >= DEPTH.
REQ-018 busy  out  1: high while INIT runs.

Function
REQ-019 FSM states: INIT and READY only.
REQ-020 INIT: the FSM writes NOP_WORD to address 0..DEPTH-1, one word per cycle, using an ADDR_W-bit counter; it moves to READY in the cycle after writing DEPTH-1, so INIT lasts exactly DEPTH cycles.
REQ-021 INIT: ld_ready=0, busy=1, rd_en ignored, instr_valid=0.
REQ-022 READY: ld_ready=1 and busy=0; the FSM stays in READY until reset.
REQ-023 Write: a load is accepted when ld_valid && ld_ready; ld_data is stored at ld_addr on that edge.
REQ-024 Fetch latency: one cycle; with rd_en=1, stall=0 and flush=0 in cycle N, instr = mem[rd_addr] and instr_valid=1 in cycle N+1.
REQ-025 No fetch: rd_en=0 with stall=0 and flush=0 gives instr_valid=0 next cycle; instr is unchanged.
REQ-026 Stall: stall=1 and flush=0 hold instr and instr_valid unchanged, and rd_en is ignored.
REQ-027 Flush: flush=1 (priority over stall and rd_en) gives instr=NOP_WORD and instr_valid=0 next cycle.
REQ-028 Write/read collision: when an accepted load and a fetch target the same address in the same cycle, the fetch returns the new ld_data (write-first bypass).
REQ-029 Out of range: a write to addr >= DEPTH is dropped and pulses addr_err.
REQ-030 Out of range: a fetch from addr >= DEPTH returns NOP_WORD with instr_valid=1 and pulses addr_err.
REQ-031 Simultaneous out-of-range write and fetch produce one addr_err pulse.
REQ-032 Stalled or flushed fetches never raise addr_err.
REQ-033 Memory contents persist across stall and flush; only reset-driven INIT clears them.

Reset
REQ-034 reset=1 at an edge sets state=INIT, init counter=0, instr=NOP_WORD, instr_valid=0, addr_err=0, busy=1, ld_ready=0.
REQ-035 Reset asserted mid-INIT or mid-READY restarts the full INIT sweep; pending loads are discarded.
REQ-036 Reset has priority over every other input.

Structure
REQ-037 Shared package instr_mem_pkg holds the state enum (INIT, READY) and the default NOP_WORD constant.
REQ-038 The storage array is one sub-module, instr_mem_array: single write port, single combinational read port, parameters DATA_W/ADDR_W/DEPTH.
REQ-039 The FSM, init counter, bypass, and output register live in the top module.

Verification
REQ-040 Reset, then hold idle for DEPTH=32 cycles -> busy=1 for exactly 32 cycles, then ld_ready=1; fetching any address 0..31 returns 0x00000000.
REQ-041 Load 0xAC230000 at addr 0 and 0x8C3F0000 at addr 1, then fetch 0,1 back-to-back -> instr 0xAC230000 then 0x8C3F0000 on consecutive cycles, instr_valid=1.
REQ-042 Fetch addr 3, then stall=1 for 3 cycles with rd_addr changing -> instr holds mem[3] for all 3 cycles; flush=1 -> next cycle instr=NOP_WORD, instr_valid=0.
REQ-043 Same cycle: load 0xFFFF0001 at addr 5 and fetch addr 5 -> next-cycle instr=0xFFFF0001.
REQ-044 DEPTH=20: load or fetch at addr 25 -> single addr_err pulse, fetch returns NOP_WORD, memory unchanged.
REQ-045 Assert reset 10 cycles into READY after loads -> INIT repeats for DEPTH cycles and all words read back as NOP_WORD.
